// File: rtl/down_counter_pkg.sv
// Shared types and defaults for the down_counter block.
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with a one-cycle terminal-count borrow pulse.
// Optional auto-reload (periodic mode) is enabled by defining DOWN_COUNTER_AUTO_RELOAD_EN.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] set,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             borrow_out,
  output logic             busy
);

  // Decrement that floors at zero: the counter never wraps to all-ones.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WIDTH'(1);
  endfunction

  state_t           state_p0, state_nxt;
  logic [WIDTH-1:0] count_p0, count_nxt;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_p0, reload_nxt;
`endif

  always_comb begin
    state_nxt = state_p0;
    count_nxt = count_p0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_nxt = reload_p0;
`endif
    if (load) begin
      if (set != '0) begin
        count_nxt = set;
        state_nxt = RUN;
      end else begin
        count_nxt = '0;
        state_nxt = IDLE;
      end
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_nxt = set;
`endif
    end else begin
      unique case (state_p0)
        IDLE: ;
        RUN: begin
          if (enable) begin
            count_nxt = sat_dec(count_p0);
            if (sat_dec(count_p0) == '0) state_nxt = DONE;
          end
        end
        DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          count_nxt = reload_p0;
          state_nxt = RUN;
`else
          state_nxt = IDLE;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Register stage: all control and datapath state updates here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0 <= IDLE;
      count_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      count_p0 <= count_nxt;
    end
  end

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) reload_p0 <= '0;
    else        reload_p0 <= reload_nxt;
  end
`endif

  assign count      = count_p0;
  assign busy       = (state_p0 == RUN);
  assign borrow_out = (state_p0 == DONE);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios plus randomized run vs. a behavioural model.
module tb_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] set = '0;
  logic         enable = 1'b0;
  logic [W-1:0] count;
  logic         borrow_out;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: remaining count, running flag, pulse flag, remembered period.
  int m_cnt    = 0;
  bit m_busy   = 1'b0;
  bit m_borrow = 1'b0;
  int m_reload = 0;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  down_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load(load), .set(set), .enable(enable),
    .count(count), .borrow_out(borrow_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_busy = 0; m_borrow = 0; m_reload = 0;
  endtask

  task automatic model_edge();
    if (load) begin
      m_cnt    = int'(set);
      m_busy   = (set != 0);
      m_borrow = 0;
      m_reload = int'(set);
    end else if (m_borrow) begin
      m_borrow = 0;
      if (AUTO) begin
        m_cnt  = m_reload;
        m_busy = 1;
      end
    end else if (m_busy && enable) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_busy   = 0;
        m_borrow = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    load = 0; set = '0; enable = 0;
    @(negedge clk);
    reset = 0;
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({count, busy, borrow_out} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d busy=%0b borrow=%0b, want 0/0/0", count, busy, borrow_out);
    end
    reset = 1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    load = 1; set = 4'd7; enable = 0;
    tick();
    load = 0;
    tick();
    n_cmp++;
    if ({count, busy} !== {4'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL async_pre: got count=%0d busy=%0b, want 7/1", count, busy);
    end
    enable = 1;
    #2 reset = 0;
    model_reset();
    #1;
    n_cmp++;
    if ({count, busy, borrow_out} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got count=%0d busy=%0b borrow=%0b, want 0/0/0", count, busy, borrow_out);
    end
    @(posedge clk);
    #2 reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({count, busy, borrow_out} !== {4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL post_reset_idle[%0d]: got count=%0d busy=%0b borrow=%0b, want 0/0/0", i, count, busy, borrow_out);
      end
    end
  endtask

  task automatic test_one_shot();
    int ec[6] = '{3, 2, 1, 0, 0, 0};
    bit eb[6] = '{1, 1, 1, 0, 0, 0};
    bit eo[6] = '{0, 0, 0, 1, 0, 0};
    apply_reset();
    if (AUTO) begin
      ec[4] = 3; eb[4] = 1;
      ec[5] = 2; eb[5] = 1;
    end
    load = 1; set = 4'h3; enable = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      load = 0;
      n_cmp++;
      if ({count, busy, borrow_out} !== {4'(ec[i]), eb[i], eo[i]}) begin
        n_fail++;
        $display("FAIL one_shot[%0d]: got count=%0d busy=%0b borrow=%0b, want %0d/%0b/%0b",
                 i, count, busy, borrow_out, ec[i], eb[i], eo[i]);
      end
    end
  endtask

  task automatic test_pause();
    int ec[8] = '{5, 4, 4, 4, 3, 2, 1, 0};
    bit en[8] = '{1, 0, 0, 1, 1, 1, 1, 1};
    apply_reset();
    load = 1; set = 4'h5; enable = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 0;
      enable = en[i];
      n_cmp++;
      if ({count, busy, borrow_out} !== {4'(ec[i]), (i != 7), (i == 7)}) begin
        n_fail++;
        $display("FAIL pause[%0d]: got count=%0d busy=%0b borrow=%0b, want %0d/%0b/%0b",
                 i, count, busy, borrow_out, ec[i], (i != 7), (i == 7));
      end
    end
  endtask

  task automatic test_zero_load();
    apply_reset();
    load = 1; set = 4'h6; enable = 1;
    tick();
    set = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      load = 0;
      n_cmp++;
      if ({count, busy, borrow_out} !== {4'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL zero_load[%0d]: got count=%0d busy=%0b borrow=%0b, want 0/0/0", i, count, busy, borrow_out);
      end
    end
  endtask

  task automatic test_load_in_done();
    apply_reset();
    load = 1; set = 4'h2; enable = 1;
    tick();
    load = 0;
    tick();
    tick();
    n_cmp++;
    if ({count, borrow_out} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL done_cycle: got count=%0d borrow=%0b, want 0/1", count, borrow_out);
    end
    load = 1; set = 4'h9;
    tick();
    load = 0;
    n_cmp++;
    if ({count, busy, borrow_out} !== {4'd9, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL load_in_done: got count=%0d busy=%0b borrow=%0b, want 9/1/0", count, busy, borrow_out);
    end
    tick();
    n_cmp++;
    if (count !== 4'd8) begin
      n_fail++;
      $display("FAIL after_done_load: got count=%0d, want 8", count);
    end
  endtask

  task automatic test_auto_reload();
    int ec[9];
    int pulses = 0;
    if (AUTO) ec = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
    else      ec = '{2, 1, 0, 0, 0, 0, 0, 0, 0};
    apply_reset();
    load = 1; set = 4'h2; enable = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      load = 0;
      if (borrow_out === 1'b1) pulses++;
      n_cmp++;
      if ({count, borrow_out} !== {4'(ec[i]), (i % 3 == 2) && (AUTO || i == 2)}) begin
        n_fail++;
        $display("FAIL auto_reload[%0d]: got count=%0d borrow=%0b, want %0d/%0b",
                 i, count, borrow_out, ec[i], (i % 3 == 2) && (AUTO || i == 2));
      end
    end
    n_cmp++;
    if (pulses != (AUTO ? 3 : 1)) begin
      n_fail++;
      $display("FAIL auto_pulses: got %0d pulses, want %0d", pulses, AUTO ? 3 : 1);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      load   = ($urandom_range(0, 7) == 0);
      set    = W'($urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, 6));
      enable = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++;
      if ({count, busy, borrow_out} !== {4'(m_cnt), m_busy, m_borrow}) begin
        n_fail++;
        $display("FAIL random[%0d]: got count=%0d busy=%0b borrow=%0b, want %0d/%0b/%0b",
                 i, count, busy, borrow_out, m_cnt, m_busy, m_borrow);
      end
      if ($urandom_range(0, 63) == 0) begin
        reset = 0;
        model_reset();
        #1;
        n_cmp++;
        if ({count, busy, borrow_out} !== {4'd0, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL random_reset[%0d]: got count=%0d busy=%0b borrow=%0b, want 0/0/0", i, count, busy, borrow_out);
        end
        #1 reset = 1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_one_shot();
    test_pause();
    test_zero_load();
    test_load_in_done();
    test_auto_reload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the set and count ports.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-004 load  input  1  when high at a clk edge, captures set into count.
REQ-005 set  input  WIDTH  load value; sampled only when load is high.
REQ-006 enable  input  1  count enable; decrement happens only when high in RUN.
REQ-007 count  output  WIDTH  current counter value, registered.
REQ-008 borrow_out  output  1  registered one-cycle pulse marking terminal count (count reached 0 from RUN).
REQ-009 busy  output  1  high while the FSM is in RUN.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE. busy = (state==RUN). borrow_out = (state==DONE).
REQ-011 Priority at every edge SHALL be reset > load > FSM transition.
REQ-012 load=1 with set!=0, in any state: count<=set, state<=RUN at that edge.
REQ-013 load=1 with set==0, in any state: count<=0, state<=IDLE, and no borrow pulse is generated.
REQ-014 In IDLE with load=0: count holds and enable is ignored.
REQ-015 In RUN with load=0, enable=0: count and state hold (pause).
REQ-016 In RUN with load=0, enable=1, count>1: count<=count-1.
REQ-017 In RUN with load=0, enable=1, count==1: count<=0, state<=DONE.
REQ-018 DONE SHALL last exactly one cycle. With load=0 the next state is IDLE, or RUN per REQ-024. A load at that edge follows REQ-012/013.
REQ-019 Latency: with load of N (N>=1) at edge k and enable held high, count SHALL be 0 and borrow_out high after edge k+N, and borrow_out low again after edge k+N+1.
REQ-020 Arithmetic SHALL be unsigned WIDTH-bit. count never wraps below 0; there is no transition from 0 to all-ones.

Reset
REQ-021 Asserting reset (low) SHALL asynchronously force count=0, state=IDLE, borrow_out=0, busy=0 and the reload register=0.
REQ-022 Reset asserted mid-RUN or mid-DONE SHALL abort the operation with no borrow pulse. After deassertion the block stays in IDLE until the next load.

Configuration
REQ-023 Macro DOWN_COUNTER_AUTO_RELOAD_EN selects auto-reload.
REQ-024 With DOWN_COUNTER_AUTO_RELOAD_EN defined:
- Every accepted load with set!=0 also stores set in a WIDTH-bit reload register.
- DONE with load=0 goes to RUN with count<=reload register.
- Result: with enable held high, borrow_out pulses periodically, every N+1 cycles.
- A load with set==0 clears the reload register and goes to IDLE.
REQ-025 Without the macro, no reload register exists and DONE always returns to IDLE (one-shot).

Structure
REQ-026 A shared package down_counter_pkg SHALL hold:
- the state typedef (IDLE, RUN, DONE);
- the default WIDTH constant.
REQ-027 The block SHALL be a single module with no sub-module. The FSM, counter datapath and optional reload register are co-located.

Verification
REQ-028 Assert reset low mid-count with count=7 -> count=0, busy=0, borrow_out=0 immediately, before the next clk edge.
REQ-029 load with set=4'h3, enable held high -> count sequence 3,2,1,0. borrow_out high only in the cycle with count=0, then IDLE, busy=0.
REQ-030 load with set=4'h5, enable low for 2 cycles after 5->4 -> count holds 4 for 2 cycles, then resumes. borrow_out occurs 2 cycles later than in the unpaused run.
REQ-031 load with set=4'h0 -> count=0, IDLE, borrow_out never asserts.
REQ-032 load with set=4'h9 during the DONE cycle of a previous run -> count=9, busy=1, borrow_out low after that edge.
REQ-033 With DOWN_COUNTER_AUTO_RELOAD_EN, load with set=4'h2, enable high -> count 2,1,0,2,1,0,... and borrow_out pulses every 3 cycles. Without the macro, a single pulse occurs, then IDLE.
